// File: rtl/fetch_pkg.sv
// Shared encodings and defaults for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    BR_SEQ   = 2'b00,
    BR_PCREL = 2'b01,
    BR_JALR  = 2'b10
  } branch_e;

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    WAIT_RESP = 2'b01,
    DRAIN     = 2'b10
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction addresses are always word aligned once loaded into pc.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready holding register between instruction memory and decode.
module fetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  logic        vld_p0;
  logic [31:0] pc_p0;
  logic [31:0] inst_p0;

  // Stage p0: a clear (redirect) beats a reload; a reload beats a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      pc_p0   <= '0;
      inst_p0 <= '0;
    end else begin
      if (clear)
        vld_p0 <= 1'b0;
      else if (load)
        vld_p0 <= 1'b1;
      else if (if_ready)
        vld_p0 <= 1'b0;
      if (load && !clear) begin
        pc_p0   <= load_pc;
        inst_p0 <= load_inst;
      end
    end
  end

  assign if_valid = vld_p0;
  assign if_pc    = pc_p0;
  assign if_inst  = inst_p0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding memory requests, branch redirect and flush.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  branchctrl,
  input  logic [31:0] pc_target,
  input  logic [31:0] jalr_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        if_ready,
  output logic        flush,
  output logic        misalign_err
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         redirect;
  logic [31:0]  target;
  logic         target_mis;
  logic         buf_free;
  logic         handshake;
  logic         buf_load;

  always_comb begin
    redirect   = 1'b0;
    target     = pc;
    target_mis = 1'b0;
    case (branchctrl)
      BR_PCREL: begin
        redirect   = 1'b1;
        target     = word_align(pc_target);
        target_mis = |pc_target[1:0];
      end
      BR_JALR: begin
        redirect   = 1'b1;
        target     = word_align(jalr_target);
        target_mis = jalr_target[1];
      end
      default: ;
    endcase
  end

  // Request side looks only at state, pc and buffer occupancy, never at branchctrl.
  assign buf_free  = !if_valid || if_ready;
  assign im_req    = rst_n && (state == FETCH) && buf_free;
  assign im_addr   = pc;
  assign handshake = im_req && im_ready;
  assign flush     = rst_n && redirect;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    buf_load  = 1'b0;
    case (state)
      FETCH: begin
        if (handshake)
          state_nxt = redirect ? DRAIN : WAIT_RESP;
      end
      WAIT_RESP: begin
        if (redirect) begin
          state_nxt = im_rvalid ? FETCH : DRAIN;
        end else if (im_rvalid) begin
          buf_load  = 1'b1;
          pc_nxt    = pc + 32'd4;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (im_rvalid)
          state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (redirect)
      pc_nxt = target;
  end

  // Stage p0: control state, pc and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      misalign_err <= misalign_err | (redirect & target_mis);
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .clear     (redirect),
    .load_pc   (pc),
    .load_inst (im_rdata),
    .if_ready  (if_ready),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios, then randomized traffic against a program-order model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  branchctrl;
  logic [31:0] pc_target, jalr_target;
  logic        im_req, im_ready, im_rvalid;
  logic [31:0] im_addr, im_rdata;
  logic        if_valid, if_ready, flush, misalign_err;
  logic [31:0] if_pc, if_inst;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branchctrl   (branchctrl),
    .pc_target    (pc_target),
    .jalr_target  (jalr_target),
    .im_req       (im_req),
    .im_addr      (im_addr),
    .im_ready     (im_ready),
    .im_rvalid    (im_rvalid),
    .im_rdata     (im_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_ready     (if_ready),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          lat_min, lat_max, pend_lat;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [31:0] next_req, exp_pc;
  logic        mis_m, prev_redir, prev_stall;
  logic [31:0] prev_pc, prev_inst;
  logic [31:0] hs_log[$];
  int          hs_cyc[$];
  logic [31:0] if_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    branchctrl = 2'b01;
    im_rvalid  = 1'b0;
    #1;
    check("rst_im_req",   im_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc",    if_pc, 0);
    check("rst_if_inst",  if_inst, 0);
    check("rst_flush",    flush, 0);
    check("rst_misalign", misalign_err, 0);
    branchctrl = 2'b00;
    pend_valid = 1'b0;
    next_req   = 32'h0;
    exp_pc     = 32'h0;
    mis_m      = 1'b0;
    prev_redir = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: memory model drives the response, checks at negedge, model advances.
  task automatic step();
    logic        redir, hs;
    logic [31:0] tgt;
    im_rvalid = pend_valid && (pend_lat == 0);
    im_rdata  = im_rvalid ? mem_word(pend_addr) : $urandom;
    @(negedge clk);
    redir = (branchctrl == 2'b01) || (branchctrl == 2'b10);
    hs    = im_req && im_ready;
    check("flush", flush, redir);
    check("misalign", misalign_err, mis_m);
    if (prev_redir) check("kill_buf", if_valid, 0);
    if (prev_stall) begin
      check("hold_pc", if_pc, prev_pc);
      check("hold_inst", if_inst, prev_inst);
    end
    if (if_valid) check("inst_data", if_inst, mem_word(if_pc));
    if (if_valid && !if_ready) check("req_stall", im_req, 0);
    if (hs) begin
      check("one_outst", pend_valid, 0);
      check("im_addr", im_addr, next_req);
      hs_log.push_back(im_addr);
      hs_cyc.push_back(cyc);
      next_req = next_req + 32'd4;
    end
    if (if_valid && if_ready && !redir) begin
      check("if_pc", if_pc, exp_pc);
      if_log.push_back(if_pc);
      exp_pc = exp_pc + 32'd4;
    end
    if (im_rvalid) pend_valid = 1'b0;
    else if (pend_valid) pend_lat--;
    if (hs) begin
      pend_valid = 1'b1;
      pend_addr  = im_addr;
      pend_lat   = $urandom_range(lat_max, lat_min);
    end
    if (redir) begin
      tgt      = (branchctrl == 2'b01) ? pc_target : jalr_target;
      tgt[1:0] = 2'b00;
      next_req = tgt;
      exp_pc   = tgt;
      if (branchctrl == 2'b01 && pc_target[1:0] != 2'b00) mis_m = 1'b1;
      if (branchctrl == 2'b10 && jalr_target[1]) mis_m = 1'b1;
    end
    prev_redir = redir;
    prev_stall = if_valid && !if_ready && !redir;
    prev_pc    = if_pc;
    prev_inst  = if_inst;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cj, r;
    rst_n = 1'b0; branchctrl = 2'b00; pc_target = '0; jalr_target = '0;
    im_ready = 1'b1; if_ready = 1'b1; im_rvalid = 1'b0; im_rdata = '0;
    lat_min = 0; lat_max = 0; pend_valid = 1'b0; pend_lat = 0; pend_addr = '0;
    do_reset();

    // Sequential fetch, then a 5-cycle decode stall holding pc 0x8.
    repeat (6) step();
    if_ready = 1'b0;
    repeat (5) step();
    check("seq_hs_cnt", hs_log.size(), 3);
    check("seq_addr0", hs_log[0], 32'h0);
    check("seq_addr1", hs_log[1], 32'h4);
    check("seq_addr2", hs_log[2], 32'h8);
    check("seq_rate", hs_cyc[1] - hs_cyc[0], 2);
    check("seq_if0", if_log[0], 32'h0);
    check("seq_if1", if_log[1], 32'h4);
    check("stall_pc", if_pc, 32'h8);
    check("stall_req", im_req, 0);

    // PC-relative redirect while a response is in flight.
    lat_min = 2; lat_max = 2; if_ready = 1'b1;
    step();
    branchctrl = 2'b01; pc_target = 32'h100;
    step();
    branchctrl = 2'b00;
    repeat (3) step();
    check("br_prev_addr", hs_log[hs_log.size()-2], 32'hC);
    check("br_addr", hs_log[hs_log.size()-1], 32'h100);

    // jalr redirects: aligned-ish target, then a misaligned one while draining.
    branchctrl = 2'b10; jalr_target = 32'h201;
    step();
    check("jalr_no_err", misalign_err, 0);
    jalr_target = 32'h203;
    step();
    branchctrl = 2'b00;
    step();
    check("jalr_err", misalign_err, 1);
    lat_min = 0; lat_max = 0;
    step();
    check("jalr_addr", hs_log[hs_log.size()-1], 32'h200);

    // Redirect coinciding with the response: no drain cycle.
    branchctrl = 2'b01; pc_target = 32'h300; cj = cyc;
    step();
    branchctrl = 2'b00;
    step();
    check("rv_redir_addr", hs_log[hs_log.size()-1], 32'h300);
    check("rv_redir_cyc", hs_cyc[hs_cyc.size()-1], cj + 1);

    // Asynchronous reset while waiting for a response.
    do_reset();
    step();
    check("rst_first_addr", hs_log[hs_log.size()-1], 32'h0);

    // Randomized traffic.
    lat_min = 0; lat_max = 3;
    for (int n = 0; n < 4000; n++) begin
      im_ready    = ($urandom_range(3, 0) != 0);
      if_ready    = ($urandom_range(3, 0) != 0);
      pc_target   = $urandom_range(4095, 0);
      jalr_target = $urandom_range(4095, 0);
      r = $urandom_range(11, 0);
      branchctrl = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      if ($urandom_range(999, 0) == 0) do_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
